// File: rtl/vga_pkg.sv
// Shared VGA raster definitions.
//
// Holds the default 640x480@60 timing constants, the derived line/frame totals and
// sync windows, the 3/3/2 colour type and a small range-decode helper used by the
// scan controller.
package vga_pkg;

  // Width of the raster counters hc/vc; line and frame totals must fit in it.
  localparam int unsigned CNT_W = 10;

  // Horizontal timing, in pixel periods.
  localparam int unsigned H_VIS  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  // Vertical timing, in lines.
  localparam int unsigned V_VIS  = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 33;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  // Inclusive sync windows in counter coordinates.
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  // 8-bit colour as driven onto the VGA resistor DAC.
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam rgb332_t RGB_BLACK = '0;

  // True when lo <= val <= hi.
  function automatic logic in_range(input logic [CNT_W-1:0] val,
                                    input int unsigned      lo,
                                    input int unsigned      hi);
    return (32'(val) >= lo) && (32'(val) <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate strobe generator.
//
// Divides the system clock by CLK_DIV and emits a one-clock pix_tick on the last
// system clock of every pixel period. With CLK_DIV = 1 the strobe is constantly high.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset (divider returns to 0)
//   pix_tick - one-clock pulse per pixel period
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  // A 1-bit counter is kept even for CLK_DIV = 1; it simply never leaves 0.
  localparam int unsigned    DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q;
  logic [DivW-1:0] div_d;

  always_comb begin
    div_d = div_q + DivW'(1);
    if (div_q == DivMax) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign pix_tick = (div_q == DivMax);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller.
//
// Produces the raster counters hc/vc consumed by the paint blocks, samples the colour
// they return for the current (hc, vc) and drives blanked, registered RGB 3/3/2 plus
// active-low hsync/vsync onto the VGA pins. Sync is registered in the same stage as
// colour, so pin colour and sync for pixel (h, v) both appear one pixel period after
// the counters present (h, v).
//
// Ports:
//   clk, rst                      - system clock, synchronous active-high reset
//   pix_red/pix_green/pix_blue    - colour from paint logic for the current hc/vc
//   hc, vc                        - raster counters (visible area starts at 0,0)
//   pix_tick                      - one-clock strobe per pixel; counters advance on it
//   active                        - current hc/vc lies in the visible area
//   frame_start                   - pix_tick at (0,0)
//   hsync, vsync                  - active-low sync, registered
//   red, green, blue              - blanked colour, registered
module vga_scan_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = vga_pkg::H_VIS,
  parameter int unsigned H_FP    = vga_pkg::H_FP,
  parameter int unsigned H_SYNC  = vga_pkg::H_SYNC,
  parameter int unsigned H_BP    = vga_pkg::H_BP,
  parameter int unsigned V_VIS   = vga_pkg::V_VIS,
  parameter int unsigned V_FP    = vga_pkg::V_FP,
  parameter int unsigned V_SYNC  = vga_pkg::V_SYNC,
  parameter int unsigned V_BP    = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] pix_red,
  input  logic [2:0] pix_green,
  input  logic [1:0] pix_blue,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       pix_tick,
  output logic       active,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue
);

  import vga_pkg::*;

  localparam int unsigned HTot    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart = H_VIS + H_FP;
  localparam int unsigned HsEnd   = HsStart + H_SYNC - 1;
  localparam int unsigned VsStart = V_VIS + V_FP;
  localparam int unsigned VsEnd   = VsStart + V_SYNC - 1;

  // Elaboration-time sanity checks on the timing parameters.
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_scan_ctrl: CLK_DIV must be >= 1");
  end
  if (HTot > (1 << CNT_W)) begin : g_bad_h_tot
    $error("vga_scan_ctrl: horizontal total exceeds 10-bit counter range");
  end
  if (VTot > (1 << CNT_W)) begin : g_bad_v_tot
    $error("vga_scan_ctrl: vertical total exceeds 10-bit counter range");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $error("vga_scan_ctrl: sync widths must be >= 1");
  end

  localparam logic [CNT_W-1:0] HLast = CNT_W'(HTot - 1);
  localparam logic [CNT_W-1:0] VLast = CNT_W'(VTot - 1);

  // ---------------------------------------------------------------------------
  // Pixel strobe
  // ---------------------------------------------------------------------------
  logic tick;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (tick)
  );

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q + CNT_W'(1);
    vc_d = vc_q;
    if (hc_q == HLast) begin
      hc_d = '0;
      if (vc_q == VLast) begin
        vc_d = '0;
      end else begin
        vc_d = vc_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the current raster position
  // ---------------------------------------------------------------------------
  logic    vis;
  logic    hs_n;
  logic    vs_n;
  rgb332_t pix_in;
  rgb332_t rgb_d;

  always_comb begin
    vis    = (32'(hc_q) < H_VIS) && (32'(vc_q) < V_VIS);
    hs_n   = !in_range(hc_q, HsStart, HsEnd);
    vs_n   = !in_range(vc_q, VsStart, VsEnd);
    pix_in = '{r: pix_red, g: pix_green, b: pix_blue};
    // Paint output is ignored outside the visible area; the pins are forced black.
    rgb_d  = vis ? pix_in : RGB_BLACK;
  end

  // ---------------------------------------------------------------------------
  // Counter and output registers; everything advances together on the strobe so
  // colour and sync for a pixel leave the block in the same cycle.
  // ---------------------------------------------------------------------------
  rgb332_t rgb_q;
  logic    hsync_q;
  logic    vsync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q    <= '0;
      vc_q    <= '0;
      rgb_q   <= RGB_BLACK;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (tick) begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      rgb_q   <= rgb_d;
      hsync_q <= hs_n;
      vsync_q <= vs_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign pix_tick    = tick;
  assign active      = vis;
  assign frame_start = tick && (hc_q == '0) && (vc_q == '0);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = rgb_q.r;
  assign green       = rgb_q.g;
  assign blue        = rgb_q.b;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl.
//
// u_dut_full : default 640x480 timing, CLK_DIV = 4 (reset, tick cadence, one full line).
// u_dut_small: shrunken raster 16x12 (vis 8x6), CLK_DIV = 4 (frames, vsync, mid-frame reset).
// u_dut_div1 : same shrunken raster with CLK_DIV = 1.
// The shrunken rasters driven by a tiny paint function let whole frames run quickly.
module tb_vga_scan_ctrl;

  // Shrunken raster: H 8+2+3+3 = 16, hsync 10..12; V 6+2+2+2 = 12, vsync 8..9.
  localparam int SHT = 16;
  localparam int SVT = 12;
  localparam int SHV = 8;
  localparam int SVV = 6;

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       tick;
    logic       act;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Full-size DUT
  logic       rst_f = 1'b1;
  logic [2:0] f_pr  = 3'd7;
  logic [2:0] f_pg  = 3'd0;
  logic [1:0] f_pb  = 2'd3;
  logic [9:0] f_hc, f_vc;
  logic       f_tick, f_act, f_fs, f_hs, f_vs;
  logic [2:0] f_r, f_g;
  logic [1:0] f_b;

  vga_scan_ctrl u_dut_full (
    .clk (clk), .rst (rst_f),
    .pix_red (f_pr), .pix_green (f_pg), .pix_blue (f_pb),
    .hc (f_hc), .vc (f_vc), .pix_tick (f_tick), .active (f_act), .frame_start (f_fs),
    .hsync (f_hs), .vsync (f_vs), .red (f_r), .green (f_g), .blue (f_b)
  );

  // Small DUT, CLK_DIV = 4
  logic       rst_s = 1'b1;
  logic [2:0] s_pr, s_pg;
  logic [1:0] s_pb;
  logic [9:0] s_hc, s_vc;
  logic       s_tick, s_act, s_fs, s_hs, s_vs;
  logic [2:0] s_r, s_g;
  logic [1:0] s_b;

  assign s_pr = s_hc[2:0];
  assign s_pg = s_vc[2:0];
  assign s_pb = s_hc[1:0] ^ s_vc[1:0];

  vga_scan_ctrl #(
    .CLK_DIV (4), .H_VIS (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_VIS (6), .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) u_dut_small (
    .clk (clk), .rst (rst_s),
    .pix_red (s_pr), .pix_green (s_pg), .pix_blue (s_pb),
    .hc (s_hc), .vc (s_vc), .pix_tick (s_tick), .active (s_act), .frame_start (s_fs),
    .hsync (s_hs), .vsync (s_vs), .red (s_r), .green (s_g), .blue (s_b)
  );

  // Small DUT, CLK_DIV = 1
  logic       rst_d = 1'b1;
  logic [2:0] d_pr, d_pg;
  logic [1:0] d_pb;
  logic [9:0] d_hc, d_vc;
  logic       d_tick, d_act, d_fs, d_hs, d_vs;
  logic [2:0] d_r, d_g;
  logic [1:0] d_b;

  assign d_pr = d_hc[2:0];
  assign d_pg = d_vc[2:0];
  assign d_pb = d_hc[1:0] ^ d_vc[1:0];

  vga_scan_ctrl #(
    .CLK_DIV (1), .H_VIS (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_VIS (6), .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) u_dut_div1 (
    .clk (clk), .rst (rst_d),
    .pix_red (d_pr), .pix_green (d_pg), .pix_blue (d_pb),
    .hc (d_hc), .vc (d_vc), .pix_tick (d_tick), .active (d_act), .frame_start (d_fs),
    .hsync (d_hs), .vsync (d_vs), .red (d_r), .green (d_g), .blue (d_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic obs_t sample(input int which);
    obs_t o;
    case (which)
      0: o = '{f_hc, f_vc, f_tick, f_act, f_fs, f_hs, f_vs, f_r, f_g, f_b};
      1: o = '{s_hc, s_vc, s_tick, s_act, s_fs, s_hs, s_vs, s_r, s_g, s_b};
      default: o = '{d_hc, d_vc, d_tick, d_act, d_fs, d_hs, d_vs, d_r, d_g, d_b};
    endcase
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until pix_tick is high (no step if already high); bounded.
  task automatic wait_tick(input int which, output int clocks);
    obs_t o;
    clocks = 0;
    o = sample(which);
    while (!o.tick && clocks < 16) begin
      step();
      clocks++;
      o = sample(which);
    end
    if (!o.tick) check("tick_timeout", 32'(o.tick), 32'd1);
  endtask

  // Run whole frames on a shrunken DUT starting at the (0,0) tick and check every pixel.
  task automatic run_frames(input int which, input string pfx, input int nframes,
                            input int div);
    obs_t o, held;
    int   h = 0, v = 0;
    int   bad_pos = 0, bad_fs = 0, bad_act = 0, bad_rgb = 0, bad_sync = 0, bad_hold = 0;
    int   hs_low = 0, vs_low = 0, fs_cnt = 0, clocks = 0, wraps = 0, waited;
    logic exp_act, exp_hs, exp_vs;
    logic [2:0] exp_r, exp_g;
    logic [1:0] exp_b;
    for (int t = 0; t < nframes * SHT * SVT; t++) begin
      o = sample(which);
      if (32'(o.hc) != h || 32'(o.vc) != v) bad_pos++;
      if (o.fs != (h == 0 && v == 0)) bad_fs++;
      if (o.fs) fs_cnt++;
      exp_act = (h < SHV) && (v < SVV);
      if (o.act != exp_act) bad_act++;
      step();
      clocks++;
      o     = sample(which);
      exp_r = exp_act ? 3'(h) : 3'd0;
      exp_g = exp_act ? 3'(v) : 3'd0;
      exp_b = exp_act ? 2'(h ^ v) : 2'd0;
      exp_hs = !(h >= 10 && h <= 12);
      exp_vs = !(v >= 8 && v <= 9);
      if (o.r != exp_r || o.g != exp_g || o.b != exp_b) bad_rgb++;
      if (o.hs != exp_hs || o.vs != exp_vs) bad_sync++;
      if (!o.hs) hs_low++;
      if (!o.vs) vs_low++;
      held   = o;
      waited = 0;
      while (!o.tick && waited < 16) begin
        step();
        clocks++;
        waited++;
        o = sample(which);
        if ({o.hs, o.vs, o.r, o.g, o.b} != {held.hs, held.vs, held.r, held.g, held.b})
          bad_hold++;
      end
      if (!o.tick) begin
        check({pfx, "_tick_timeout"}, 32'(o.tick), 32'd1);
        return;
      end
      if (h == SHT - 1) begin
        h = 0;
        if (v == SVT - 1) begin
          v = 0;
          wraps++;
        end else begin
          v++;
        end
      end else begin
        h++;
      end
    end
    o = sample(which);
    check({pfx, "_bad_pos"},      32'(bad_pos),  32'd0);
    check({pfx, "_bad_fs"},       32'(bad_fs),   32'd0);
    check({pfx, "_bad_active"},   32'(bad_act),  32'd0);
    check({pfx, "_bad_rgb"},      32'(bad_rgb),  32'd0);
    check({pfx, "_bad_sync"},     32'(bad_sync), 32'd0);
    check({pfx, "_bad_hold"},     32'(bad_hold), 32'd0);
    check({pfx, "_hs_low"},       32'(hs_low),   32'(nframes * SVT * 3));
    check({pfx, "_vs_low"},       32'(vs_low),   32'(nframes * 2 * SHT));
    check({pfx, "_fs_count"},     32'(fs_cnt),   32'(nframes));
    check({pfx, "_clocks"},       32'(clocks),   32'(nframes * SHT * SVT * div));
    check({pfx, "_wrap_hc"},      32'(o.hc),     32'd0);
    check({pfx, "_wrap_vc"},      32'(o.vc),     32'd0);
    check({pfx, "_wrap_count"},   32'(wraps),    32'(nframes));
  endtask

  initial begin
    obs_t o;
    int   clocks;
    int   bad_hc, bad_rgb, bad_hs, hs_low, hs_first, vs_low, ticks;
    logic exp_hs;

    // ---------------- Full-size DUT: reset and first ticks ----------------
    repeat (3) step();
    o = sample(0);
    check("rst_hc",     32'(o.hc),   32'd0);
    check("rst_vc",     32'(o.vc),   32'd0);
    check("rst_hsync",  32'(o.hs),   32'd1);
    check("rst_vsync",  32'(o.vs),   32'd1);
    check("rst_rgb",    32'({o.r, o.g, o.b}), 32'd0);
    check("rst_tick",   32'(o.tick), 32'd0);
    check("rst_active", 32'(o.act),  32'd1);
    check("rst_fs",     32'(o.fs),   32'd0);

    rst_f = 1'b0;
    step();
    o = sample(0);
    check("tick_clk1", 32'(o.tick), 32'd0);
    step();
    o = sample(0);
    check("tick_clk2", 32'(o.tick), 32'd0);
    step();
    o = sample(0);
    check("tick_clk3",    32'(o.tick), 32'd1);
    check("first_fs",     32'(o.fs),   32'd1);
    check("first_tick_hc", 32'(o.hc),  32'd0);

    // ---------------- Full-size DUT: one line ----------------
    bad_hc = 0; bad_rgb = 0; bad_hs = 0; hs_low = 0; hs_first = -1; vs_low = 0;
    for (int p = 0; p < 800; p++) begin
      o = sample(0);
      if (32'(o.hc) != p || o.vc != 10'd0) bad_hc++;
      step();
      o = sample(0);
      if (o.r != ((p < 640) ? 3'd7 : 3'd0) || o.g != 3'd0 ||
          o.b != ((p < 640) ? 2'd3 : 2'd0)) bad_rgb++;
      exp_hs = !(p >= 656 && p <= 751);
      if (o.hs != exp_hs) bad_hs++;
      if (!o.hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = p;
      end
      if (!o.vs) vs_low++;
      wait_tick(0, clocks);
      if (clocks != 3) bad_hc++;
    end
    o = sample(0);
    check("line_bad_pos",  32'(bad_hc),   32'd0);
    check("line_bad_rgb",  32'(bad_rgb),  32'd0);
    check("line_bad_hs",   32'(bad_hs),   32'd0);
    check("line_hs_low",   32'(hs_low),   32'd96);
    check("line_hs_first", 32'(hs_first), 32'd656);
    check("line_vs_low",   32'(vs_low),   32'd0);
    check("line_wrap_hc",  32'(o.hc),     32'd0);
    check("line_wrap_vc",  32'(o.vc),     32'd1);

    // ---------------- Small DUT: two frames ----------------
    rst_s = 1'b0;
    wait_tick(1, clocks);
    check("small_first_tick_clocks", 32'(clocks), 32'd3);
    run_frames(1, "small", 2, 4);

    // ---------------- Small DUT: reset inside hsync and vsync ----------------
    ticks = 0;
    o = sample(1);
    while (!(o.hc == 10'd11 && o.vc == 10'd9) && ticks < 400) begin
      step();
      wait_tick(1, clocks);
      ticks++;
      o = sample(1);
    end
    check("mid_reach_pos", 32'({o.hc, o.vc}), 32'({10'd11, 10'd9}));
    step();
    step();
    o = sample(1);
    check("mid_pre_hsync", 32'(o.hs), 32'd0);
    check("mid_pre_vsync", 32'(o.vs), 32'd0);
    rst_s = 1'b1;
    step();
    o = sample(1);
    check("mid_rst_hc",    32'(o.hc),   32'd0);
    check("mid_rst_vc",    32'(o.vc),   32'd0);
    check("mid_rst_hsync", 32'(o.hs),   32'd1);
    check("mid_rst_vsync", 32'(o.vs),   32'd1);
    check("mid_rst_rgb",   32'({o.r, o.g, o.b}), 32'd0);
    check("mid_rst_tick",  32'(o.tick), 32'd0);
    rst_s = 1'b0;
    wait_tick(1, clocks);
    check("restart_tick_clocks", 32'(clocks), 32'd3);
    run_frames(1, "restart", 1, 4);

    // ---------------- CLK_DIV = 1 DUT ----------------
    o = sample(2);
    check("div1_tick_in_rst", 32'(o.tick), 32'd1);
    rst_d = 1'b0;
    o = sample(2);
    check("div1_fs", 32'(o.fs), 32'd1);
    run_frames(2, "div1", 2, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Scan-side counterpart of the paint blocks.
- Generates the 640x480@60 raster counters hc/vc that every paint_* block consumes, plus hsync/vsync.
- Samples the colour the selected paint block returns for the current (hc, vc).
- Drives the blanked, registered RGB (3/3/2) onto the VGA pins, with sync delayed to stay aligned with colour.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be >= 1
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset
- pix_red, in, 3, colour from paint logic for current hc/vc
- pix_green, in, 3, colour from paint logic
- pix_blue, in, 2, colour from paint logic
- hc, out, 10, horizontal counter; 0..H_VIS-1 visible, total 0..799
- vc, out, 10, vertical counter; 0..V_VIS-1 visible, total 0..524
- pix_tick, out, 1, one-clk pulse per pixel; hc/vc advance after it
- active, out, 1, (hc < H_VIS) && (vc < V_VIS), combinational from counters
- frame_start, out, 1, pulse coincident with pix_tick when hc=0, vc=0
- hsync, out, 1, active-low, registered
- vsync, out, 1, active-low, registered
- red, out, 3, VGA red, registered
- green, out, 3, VGA green, registered
- blue, out, 2, VGA blue, registered

Behaviour:
- Reset values (clock after rst=1): div counter 0, hc=0, vc=0, hsync=1, vsync=1, red/green/blue=0. pix_tick, frame_start and active follow from the reset counter values.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_tick=1 when div==CLK_DIV-1. With CLK_DIV=1, pix_tick is constant 1 out of reset.
- Counters update only on pix_tick:
  - hc==H_TOT-1 (800-1): hc<=0, and vc advances (vc==V_TOT-1 (525-1) -> 0); otherwise hc<=hc+1.
  - Widths are 10 bits; totals must be <= 1024, checked by an elaboration-time assertion.
- Sync decode (combinational, then registered):
  - hs_n = !(hc in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]), i.e. 656..751.
  - vs_n = !(vc in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1]), i.e. 490..491.
- Output stage, captured on pix_tick from the current counters:
  - red/green/blue <= active ? pix_* : 0; hsync<=hs_n; vsync<=vs_n.
  - Outputs hold between ticks.
- Latency: paint logic is combinational, same pixel period. Pin colour/sync for pixel (h,v) appears one pixel period after hc/vc present (h,v). Sync and colour are always mutually aligned.
- Line rate = 800 ticks; frame = 420000 ticks. frame_start fires exactly once per frame.
- Wrap at (799,524) -> (0,0) in one tick, no extra dead cycle.
- rst asserted mid-line/mid-frame: next clock returns everything to reset values. Raster restarts at (0,0), with no partial sync pulse extension.
- pix_* inputs are don't-care while active=0; outputs are forced 0 regardless.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants H_VIS/H_FP/H_SYNC/H_BP/V_* and derived H_TOT=800, V_TOT=525;
  - HS_START/HS_END, VS_START/VS_END;
  - colour typedefs: rgb332 with r[2:0], g[2:0], b[1:0].
- One natural sub-module: vga_pix_div, which emits pix_tick from clk/rst/CLK_DIV. Counters and output stage stay in the top.

Test Plan:
- Reset release, CLK_DIV=4 -> pix_tick every 4th clk (first at clk 3); hc=0, vc=0, hsync=vsync=1, rgb=0; frame_start on first tick.
- Drive pix_red=7, green=0, blue=3 constant; sample one line -> red=7/blue=3 on pins for pixels 0..639 (one pixel late); 0 for pixels 640..799.
- Run one line -> hsync low exactly 96 pixel periods, first low output after the tick where hc=656; next tick after hc=799 gives hc=0, vc=1.
- Run one full frame -> vsync low for lines 490..491 only (1600 ticks); frame_start count =1 per 420000 ticks; (799,524) wraps to (0,0).
- Assert rst at hc=700 (inside hsync), vc=491 -> next clk hsync=vsync=1, hc=vc=0, rgb=0; raster restarts cleanly.
- CLK_DIV=1 build -> pix_tick constantly 1; full frame is 420000 clocks; same sync checks pass.
